kbd_cmd_scheduler: RTL
======================

Name: kbd_cmd_scheduler

Overview:
- Sits between the PS/2 keyboard adapter and the game logic, in a single clock domain. It decodes scan-code events into game commands and buffers them in a small FIFO.
- Commands are released to the game logic at a rate of at most one per game tick, using a valid/ready handshake.
- It replaces the per-key toggle/edge-detect scheme, so rapid or simultaneous keypresses are queued rather than lost or merged.

Parameters:
- DEPTH, 8, FIFO entries; must be a power of 2, minimum 2.
- REPEAT_DELAY, 25, ticks a direction key must be held before auto-repeat starts (used only with the optional feature).
- REPEAT_RATE, 5, ticks between auto-repeat commands (used only with the optional feature).

Ports:
- clk  in  1  system clock; single clock for the whole block.
- reset  in  1  synchronous, active-high.
- make_pulse  in  1  one-cycle strobe; scan_code holds a key-press.
- break_pulse  in  1  one-cycle strobe; scan_code holds a key-release.
- scan_code  in  8  PS/2 set-2 code; valid only while a pulse is high.
- tick  in  1  one-cycle game-step strobe.
- game_over  in  1  level; the game has ended.
- cmd_ready  in  1  game logic accepts cmd_code this cycle.
- cmd_valid  out  1  cmd_code is presented.
- cmd_code  out  4  command: 1 LEFT, 2 RIGHT, 3 UP, 4 DOWN, 5 PLACE, 6 ROTATE, 7 SEL1, 8 SEL2, 9 SEL3.
- fifo_count  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky; a command was dropped because the FIFO was full.

Behaviour:
- Reset: the clock is clk; reset is synchronous and active-high. On reset: cmd_valid=0, cmd_code=0, fifo_count=0, overflow=0, FSM=S_IDLE, repeat state cleared. Reset mid-handshake drops the presented command.
- Decode (make_pulse only):
  - 6B/1C → LEFT
  - 74/23 → RIGHT
  - 75/1D → UP
  - 72/1B → DOWN
  - 29 → PLACE
  - 2D → ROTATE
  - 16 → SEL1
  - 1E → SEL2
  - 26 → SEL3
  - Any other code is ignored; no push.
- Push: a decoded command is written at the end of the pulse cycle and fifo_count increments one cycle later.
  - If full and no pop occurs that cycle: the push is dropped and overflow is set to 1. overflow stays set until reset.
  - Push and pop in the same cycle: count unchanged, and the push succeeds even when full.
- FSM:
  - S_IDLE: waits for tick. On tick with count>0, go to S_PRESENT next cycle. On tick with count=0, stay in S_IDLE.
  - S_PRESENT: cmd_valid=1 and cmd_code=FIFO head, both held stable until cmd_ready.
    - On cmd_valid&cmd_ready: pop the head, cmd_valid=0 next cycle, return to S_IDLE.
    - tick pulses during S_PRESENT are ignored and not counted.
- Latency:
  - tick at cycle N with a non-empty FIFO → cmd_valid=1 at N+1.
  - cmd_ready at N+1 → cmd_valid=0 at N+2.
  - A command pushed in cycle N may be presented on a tick at N+1 at the earliest.
  - At most one command is handshaken per tick.
- FIFO: order is preserved, pointers wrap modulo DEPTH, and the read data is the head entry (no bubble).
- game_over=1 (level):
  - The FIFO is flushed and fifo_count=0 next cycle.
  - cmd_valid is forced to 0 next cycle, aborting any pending command.
  - The FSM goes to S_IDLE and all pushes are dropped without setting overflow.
  - Normal operation resumes the cycle after game_over deasserts.
- Simultaneous make_pulse and break_pulse: make_pulse is processed; break_pulse is ignored.

Optional Feature:
- KEY_REPEAT_EN defined:
  - Tracks one held direction key, namely the last LEFT/RIGHT/UP/DOWN make.
  - A break_pulse whose scan_code maps to that same command releases it. A new direction make replaces the held key and restarts the counts.
  - After REPEAT_DELAY ticks held, one copy of the command is pushed on the tick cycle. After that, one copy is pushed every REPEAT_RATE ticks.
  - If a keyboard push occurs in the same cycle, the keyboard push wins and that repeat is skipped.
  - A repeat push into a full FIFO sets overflow.
  - game_over clears the held state.
- KEY_REPEAT_EN undefined: break_pulse is ignored, no repeat logic is present, and behaviour is otherwise identical.

Test Plan:
- Reset, then make 6B with no tick for 10 cycles → fifo_count=1, cmd_valid=0. Tick at N → cmd_valid=1, cmd_code=1 at N+1. cmd_ready at N+1 → fifo_count=0, cmd_valid=0 at N+2.
- Makes 29, 2D, 16 back-to-back, with cmd_ready tied high and ticks every 20 cycles → cmd_code sequence 5, 6, 7, one command per tick.
- DEPTH=8: 9 makes of 74 with no tick → fifo_count=8, overflow=1. The 9th push is lost, and overflow stays 1 after the FIFO drains.
- Hold cmd_ready=0 for 3 ticks with 2 entries queued → cmd_valid high and cmd_code stable throughout, and fifo_count stays at 2. When cmd_ready rises, exactly one pop occurs.
- 4 entries queued with cmd_valid=1, then game_over=1 → next cycle cmd_valid=0 and fifo_count=0. A make during game_over is dropped with overflow=0.
- KEY_REPEAT_EN, REPEAT_DELAY=3, REPEAT_RATE=2: make 72, 10 ticks, then break 72 → DOWN pushed at make, then at held ticks 3, 5, 7 and 9, giving 5 total. No pushes occur after the break.

Source files
------------

// File: rtl/kbd_cmd_scheduler.sv
// kbd_cmd_scheduler: turns PS/2 set-2 make events into game commands.
// The commands are queued in a small FIFO and handed to the game logic
// at a rate of at most one per game tick, using a valid/ready handshake.
// Optional build macro KEY_REPEAT_EN: when it is defined, a held
// direction key auto-repeats on game ticks. When it is undefined,
// break_pulse is ignored and no repeat logic is built.
//
// Handshake: cmd_valid rises only in response to a tick and then stays
// high. cmd_code stays stable until the cycle in which cmd_ready is
// sampled high while cmd_valid is high. In that cycle the head entry is
// popped, and cmd_valid is low again in the following cycle.

module kbd_cmd_scheduler #(
    parameter int DEPTH        = 8,
    parameter int REPEAT_DELAY = 25,
    parameter int REPEAT_RATE  = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     make_pulse,
    input  logic                     break_pulse,
    input  logic [7:0]               scan_code,
    input  logic                     tick,
    input  logic                     game_over,
    input  logic                     cmd_ready,
    output logic                     cmd_valid,
    output logic [3:0]               cmd_code,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic                     state_dbg
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Reject parameter sets that the pointer and counter logic cannot support.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
        $error("kbd_cmd_scheduler: DEPTH must be a power of two >= 2; repeat counts must be >= 1");
    end

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_PRESENT = 1'b1
    } state_t;

    state_t state;

    // Scan code to command map; 0 means "not a game key".
    function automatic logic [3:0] decode(input logic [7:0] sc);
        logic [3:0] c;
        c = 4'd0;
        case (sc)
            8'h6B, 8'h1C: c = 4'd1;   // LEFT
            8'h74, 8'h23: c = 4'd2;   // RIGHT
            8'h75, 8'h1D: c = 4'd3;   // UP
            8'h72, 8'h1B: c = 4'd4;   // DOWN
            8'h29:        c = 4'd5;   // PLACE
            8'h2D:        c = 4'd6;   // ROTATE
            8'h16:        c = 4'd7;   // SEL1
            8'h1E:        c = 4'd8;   // SEL2
            8'h26:        c = 4'd9;   // SEL3
            default:      c = 4'd0;
        endcase
        return c;
    endfunction

    logic [3:0]    dec_cmd;
    logic          kbd_push;
    logic          rep_fire;
    logic [3:0]    rep_cmd;
    logic          push_req;
    logic [3:0]    push_cmd;
    logic          full;
    logic          do_pop;
    logic          do_push;
    logic          drop;

    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign dec_cmd  = decode(scan_code);
    assign kbd_push = make_pulse && (dec_cmd != 4'd0);

    // A keyboard push and a repeat push never share a cycle: the keyboard wins.
    assign push_cmd = kbd_push ? dec_cmd : rep_cmd;
    assign push_req = (kbd_push || rep_fire) && !game_over;
    assign full     = (fifo_count == CW'(DEPTH));
    assign do_pop   = (state == S_PRESENT) && cmd_ready && !game_over;

    // A push into a full FIFO still succeeds when the head is popped in the same cycle.
    assign do_push  = push_req && (!full || do_pop);
    assign drop     = push_req && full && !do_pop;

    assign state_dbg = (state == S_PRESENT);

`ifdef KEY_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

    logic          held_valid;
    logic [3:0]    held_cmd;
    logic          rep_phase;   // 0: waiting out the initial delay, 1: repeating
    logic [RW-1:0] rep_cnt;
    logic          make_dir;
    logic          release_key;
    logic          rep_due;

    assign make_dir    = make_pulse && (dec_cmd >= 4'd1) && (dec_cmd <= 4'd4);
    assign release_key = break_pulse && !make_pulse && held_valid && (dec_cmd == held_cmd);
    assign rep_due     = rep_phase ? (rep_cnt == RATE_LAST) : (rep_cnt == DELAY_LAST);
    assign rep_fire    = held_valid && tick && rep_due && !kbd_push && !release_key;
    assign rep_cmd     = held_cmd;

    // Track the last held direction key and count ticks toward its next repeat.
    always_ff @(posedge clk) begin
        if (reset || game_over) begin
            held_valid <= 1'b0;
            held_cmd   <= 4'd0;
            rep_phase  <= 1'b0;
            rep_cnt    <= '0;
        end else if (make_dir) begin
            held_valid <= 1'b1;
            held_cmd   <= dec_cmd;
            rep_phase  <= 1'b0;
            rep_cnt    <= '0;
        end else if (release_key) begin
            held_valid <= 1'b0;
            rep_phase  <= 1'b0;
            rep_cnt    <= '0;
        end else if (held_valid && tick) begin
            if (rep_due) begin
                rep_phase <= 1'b1;
                rep_cnt   <= '0;
            end else begin
                rep_cnt <= rep_cnt + 1'b1;
            end
        end
    end
`else
    logic unused_break;

    assign rep_fire     = 1'b0;
    assign rep_cmd      = 4'd0;
    assign unused_break = break_pulse;
`endif

    // FIFO storage; the entries need no reset because the count guards every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_cmd;
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else if (game_over) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Release FSM: present the head entry on a tick, then hold it until the handshake.
    always_ff @(posedge clk) begin
        if (reset || game_over) begin
            state     <= S_IDLE;
            cmd_valid <= 1'b0;
            cmd_code  <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (tick && (fifo_count != '0)) begin
                        state     <= S_PRESENT;
                        cmd_valid <= 1'b1;
                        cmd_code  <= mem[rd_ptr];
                    end
                end
                S_PRESENT: begin
                    if (cmd_ready) begin
                        state     <= S_IDLE;
                        cmd_valid <= 1'b0;
                        cmd_code  <= 4'd0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    cmd_valid <= 1'b0;
                    cmd_code  <= 4'd0;
                end
            endcase
        end
    end

endmodule
